// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared definitions for the MEM/WB stage.
//   - register/memory bus widths, reset and write-enable levels
//   - memory operation codes carried from EX
//   - FSM state encoding of the stage
//   - is_mem_op(): true for opcodes that use the SRAM bus
package mem_wb_stage_pkg;

    localparam int unsigned RegBusW     = 16;
    localparam int unsigned RegAddrBusW = 4;
    localparam int unsigned MemAddrW    = 16;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteDisable = 1'b0;

    typedef enum logic [1:0] {
        MemOpNone  = 2'd0,
        MemOpLoad  = 2'd1,
        MemOpStore = 2'd2
    } mem_op_e;

    typedef enum logic {
        MemStIdle = 1'b0,
        MemStBusy = 1'b1
    } mem_st_e;

    // Opcode 3 is reserved and behaves like MemOpNone.
    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MemOpLoad) || (op == MemOpStore);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: shared 16-bit SRAM bus with a req/ack handshake.
//   req   : request held high for the whole access
//   we    : 1 = store, 0 = load
//   addr  : word address
//   wdata : store data
//   rdata : load data, valid while ack is high
//   ack   : access completes this cycle
// master = the pipeline stage, slave = the memory controller.
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = RegBusW,
    parameter int unsigned MADDR_W = MemAddrW
);

    logic               req;
    logic               we;
    logic [MADDR_W-1:0] addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic               ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );

endinterface

// File: rtl/mem_bus_timer.sv
// mem_bus_timer: counts cycles spent waiting for a bus acknowledge.
//   clk, rst : clock and synchronous active-high reset
//   clear    : return the count to 0 (wins over enable)
//   enable   : count one more waiting cycle
//   expired  : the count has reached TIMEOUT-1
module mem_bus_timer
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expired = (cnt_q == CntLast);

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back stage of the pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   ex_*                : instruction from EX (valid, wreg, waddr, wdata, memop, maddr, sdata)
//   stall_o             : stage busy with a bus access; EX must hold
//   mem                 : SRAM bus master port (req/we/addr/wdata out, rdata/ack in)
//   wb_we_o/waddr/wdata : registered one-cycle regfile write
//   err_o               : one-cycle pulse when a bus access times out
// ALU results are written back one cycle after acceptance. A load/store
// latches its operands, holds the bus request until ack or timeout, then
// returns to IDLE in the same cycle the write-back (or error) appears.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = RegBusW,
    parameter int unsigned MADDR_W = MemAddrW,
    parameter int unsigned RADDR_W = RegAddrBusW,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               ex_valid_i,
    input  logic               ex_wreg_i,
    input  logic [RADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic [1:0]         ex_memop_i,
    input  logic [MADDR_W-1:0] ex_maddr_i,
    input  logic [DATA_W-1:0]  ex_sdata_i,

    output logic               stall_o,
    mem_wb_stage_if.master     mem,

    output logic               wb_we_o,
    output logic [RADDR_W-1:0] wb_waddr_o,
    output logic [DATA_W-1:0]  wb_wdata_o,
    output logic               err_o
);

    mem_st_e            state_q;
    logic               lat_wreg_q;
    logic [RADDR_W-1:0] lat_waddr_q;
    logic [MADDR_W-1:0] lat_maddr_q;
    logic [DATA_W-1:0]  lat_sdata_q;
    logic               lat_we_q;
    logic               busy;
    logic               expired;

    assign busy = (state_q == MemStBusy);

    mem_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!busy),
        .enable  (busy && !mem.ack),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= MemStIdle;
            lat_wreg_q  <= 1'b0;
            lat_waddr_q <= '0;
            lat_maddr_q <= '0;
            lat_sdata_q <= '0;
            lat_we_q    <= 1'b0;
            wb_we_o     <= WriteDisable;
            wb_waddr_o  <= '0;
            wb_wdata_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            // Write-back and error are single-cycle pulses by default.
            wb_we_o <= WriteDisable;
            err_o   <= 1'b0;
            unique case (state_q)
                MemStIdle: begin
                    if (ex_valid_i) begin
                        if (is_mem_op(ex_memop_i)) begin
                            lat_wreg_q  <= ex_wreg_i;
                            lat_waddr_q <= ex_waddr_i;
                            lat_maddr_q <= ex_maddr_i;
                            lat_sdata_q <= ex_sdata_i;
                            lat_we_q    <= (ex_memop_i == MemOpStore);
                            state_q     <= MemStBusy;
                        end else begin
                            wb_we_o    <= ex_wreg_i;
                            wb_waddr_o <= ex_waddr_i;
                            wb_wdata_o <= ex_wdata_i;
                        end
                    end
                end
                MemStBusy: begin
                    if (mem.ack) begin
                        if (!lat_we_q) begin
                            wb_we_o    <= lat_wreg_q;
                            wb_waddr_o <= lat_waddr_q;
                            wb_wdata_o <= mem.rdata;
                        end
                        state_q <= MemStIdle;
                    end else if (expired) begin
                        err_o   <= 1'b1;
                        state_q <= MemStIdle;
                    end
                end
                default: state_q <= MemStIdle;
            endcase
        end
    end

    // Bus and stall depend only on state, never on ex_* or ack.
    assign stall_o   = busy;
    assign mem.req   = busy;
    assign mem.we    = busy && lat_we_q;
    assign mem.addr  = busy ? lat_maddr_q : '0;
    assign mem.wdata = busy ? lat_sdata_q : '0;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: inputs are driven and outputs sampled on the
// falling edge; expected values come from the stage's cycle rules.
module tb_mem_wb_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_wreg = 1'b0;
    logic [3:0]  ex_waddr = '0;
    logic [15:0] ex_wdata = '0;
    logic [1:0]  ex_memop = '0;
    logic [15:0] ex_maddr = '0;
    logic [15:0] ex_sdata = '0;
    logic        stall;
    logic        wb_we;
    logic [3:0]  wb_waddr;
    logic [15:0] wb_wdata;
    logic        err;

    int total = 0;
    int bad = 0;

    mem_wb_stage_if #(.DATA_W(16), .MADDR_W(16)) bus ();

    mem_wb_stage #(
        .DATA_W  (16),
        .MADDR_W (16),
        .RADDR_W (4),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid_i (ex_valid),
        .ex_wreg_i  (ex_wreg),
        .ex_waddr_i (ex_waddr),
        .ex_wdata_i (ex_wdata),
        .ex_memop_i (ex_memop),
        .ex_maddr_i (ex_maddr),
        .ex_sdata_i (ex_sdata),
        .stall_o    (stall),
        .mem        (bus),
        .wb_we_o    (wb_we),
        .wb_waddr_o (wb_waddr),
        .wb_wdata_o (wb_wdata),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          store;
        bit          wreg;
        logic [3:0]  waddr;
        logic [15:0] maddr;
        logic [15:0] sdata;
        logic [15:0] rdata;
        int          k;      // ack in busy cycle k; 0 = never ack
    } mop_t;

    task automatic drive_random_ex();
        ex_valid = 1'($urandom);
        ex_wreg  = 1'($urandom);
        ex_waddr = 4'($urandom);
        ex_wdata = 16'($urandom);
        ex_memop = 2'($urandom);
        ex_maddr = 16'($urandom);
        ex_sdata = 16'($urandom);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_random_ex();
        ex_valid = 1'b1;
        ex_memop = 2'd1;
        repeat (2) @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall); end
        total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", bus.req); end
        total++; if ({bus.we, bus.addr, bus.wdata} !== 33'd0) begin bad++; $display("FAIL reset_bus got %h want 0", {bus.we, bus.addr, bus.wdata}); end
        total++; if ({wb_we, wb_waddr, wb_wdata, err} !== 22'd0) begin bad++; $display("FAIL reset_wb got %h want 0", {wb_we, wb_waddr, wb_wdata, err}); end
        rst = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        total++; if ({stall, wb_we, err} !== 3'b000) begin bad++; $display("FAIL reset_idle got %b want 000", {stall, wb_we, err}); end
    endtask

    task automatic test_alu_passthrough();
        localparam int N = 32;
        bit          e_we = 1'b0;
        logic [3:0]  e_addr = '0;
        logic [15:0] e_data = '0;
        for (int n = 0; n <= N; n++) begin
            @(negedge clk);
            if (n > 0) begin
                total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall op%0d got %b want 0", n, stall); end
                total++; if (wb_we !== e_we) begin bad++; $display("FAIL alu_we op%0d got %b want %b", n, wb_we, e_we); end
                if (e_we) begin
                    total++; if (wb_waddr !== e_addr) begin bad++; $display("FAIL alu_waddr op%0d got %h want %h", n, wb_waddr, e_addr); end
                    total++; if (wb_wdata !== e_data) begin bad++; $display("FAIL alu_wdata op%0d got %h want %h", n, wb_wdata, e_data); end
                end
            end
            if (n < N) begin
                drive_random_ex();
                ex_memop = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
                if (n < 2) begin
                    ex_valid = 1'b1;
                    ex_wreg  = 1'b1;
                    ex_waddr = 4'd3;
                    ex_wdata = (n == 0) ? 16'h1234 : 16'h5678;
                end
                e_we   = ex_valid && ex_wreg;
                e_addr = ex_waddr;
                e_data = ex_wdata;
            end else begin
                ex_valid = 1'b0;
            end
        end
    endtask

    task automatic test_mem_ops();
        mop_t ops[$];
        mop_t op;
        int   busy_len;
        bit   e_we;
        logic [3:0]  f_addr;
        logic [15:0] f_data;
        op.store = 1'b0; op.wreg = 1'b1; op.waddr = 4'd5; op.maddr = 16'h8000;
        op.sdata = 16'h0; op.rdata = 16'hBEEF; op.k = 3;
        ops.push_back(op);
        op.store = 1'b1; op.wreg = 1'b1; op.waddr = 4'd6; op.maddr = 16'h0010;
        op.sdata = 16'hA5A5; op.rdata = 16'h0; op.k = 1;
        ops.push_back(op);
        op.store = 1'b0; op.wreg = 1'b1; op.waddr = 4'd7; op.maddr = 16'h0040;
        op.sdata = 16'h0; op.rdata = 16'h1111; op.k = 0;
        ops.push_back(op);
        for (int r = 0; r < 12; r++) begin
            op.store = 1'($urandom); op.wreg = 1'($urandom); op.waddr = 4'($urandom);
            op.maddr = 16'($urandom); op.sdata = 16'($urandom); op.rdata = 16'($urandom);
            op.k = int'($urandom_range(0, TO));
            ops.push_back(op);
        end
        foreach (ops[n]) begin
            op = ops[n];
            @(negedge clk);
            ex_valid = 1'b1;
            ex_memop = op.store ? 2'd2 : 2'd1;
            ex_wreg  = op.wreg;
            ex_waddr = op.waddr;
            ex_wdata = 16'($urandom);
            ex_maddr = op.maddr;
            ex_sdata = op.sdata;
            busy_len = (op.k == 0) ? int'(TO) : op.k;
            for (int j = 1; j <= busy_len; j++) begin
                @(negedge clk);
                total++; if ({stall, bus.req} !== 2'b11) begin bad++; $display("FAIL mem_busy op%0d cyc%0d stall/req got %b want 11", n, j, {stall, bus.req}); end
                total++; if (bus.addr !== op.maddr) begin bad++; $display("FAIL mem_addr op%0d cyc%0d got %h want %h", n, j, bus.addr, op.maddr); end
                total++; if (bus.we !== op.store) begin bad++; $display("FAIL mem_we op%0d cyc%0d got %b want %b", n, j, bus.we, op.store); end
                if (op.store) begin
                    total++; if (bus.wdata !== op.sdata) begin bad++; $display("FAIL mem_wdata op%0d cyc%0d got %h want %h", n, j, bus.wdata, op.sdata); end
                end
                total++; if ({wb_we, err} !== 2'b00) begin bad++; $display("FAIL mem_busy_wb op%0d cyc%0d we/err got %b want 00", n, j, {wb_we, err}); end
                // EX keeps changing while stalled; the stage must ignore it.
                drive_random_ex();
                bus.ack   = (j == op.k);
                bus.rdata = (j == op.k) ? op.rdata : 16'($urandom);
            end
            @(negedge clk);
            bus.ack = 1'b0;
            e_we = (op.k != 0) && !op.store && op.wreg;
            total++; if ({stall, bus.req} !== 2'b00) begin bad++; $display("FAIL mem_done op%0d stall/req got %b want 00", n, {stall, bus.req}); end
            total++; if (err !== (op.k == 0)) begin bad++; $display("FAIL mem_err op%0d got %b want %b", n, err, op.k == 0); end
            total++; if (wb_we !== e_we) begin bad++; $display("FAIL mem_wb_we op%0d got %b want %b", n, wb_we, e_we); end
            if (e_we) begin
                total++; if (wb_waddr !== op.waddr) begin bad++; $display("FAIL mem_wb_waddr op%0d got %h want %h", n, wb_waddr, op.waddr); end
                total++; if (wb_wdata !== op.rdata) begin bad++; $display("FAIL mem_wb_wdata op%0d got %h want %h", n, wb_wdata, op.rdata); end
            end
            // Next ALU op is accepted right away; a late ack must do nothing.
            f_addr = 4'($urandom);
            f_data = 16'($urandom);
            ex_valid = 1'b1; ex_memop = 2'd0; ex_wreg = 1'b1;
            ex_waddr = f_addr; ex_wdata = f_data;
            if (op.k == 0) begin
                bus.ack = 1'b1;
                bus.rdata = 16'($urandom);
            end
            @(negedge clk);
            bus.ack = 1'b0;
            ex_valid = 1'b0;
            total++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, f_addr, f_data}) begin bad++; $display("FAIL mem_next_alu op%0d got %h want %h", n, {wb_we, wb_waddr, wb_wdata}, {1'b1, f_addr, f_data}); end
            total++; if ({stall, bus.req, err} !== 3'b000) begin bad++; $display("FAIL mem_after op%0d stall/req/err got %b want 000", n, {stall, bus.req, err}); end
        end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        ex_valid = 1'b1; ex_memop = 2'd1; ex_wreg = 1'b1; ex_waddr = 4'd9;
        ex_maddr = 16'h1357; ex_sdata = 16'h2468;
        @(negedge clk);
        ex_valid = 1'b0;
        total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL rstbusy_req got %b want 1", bus.req); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if ({stall, bus.req, bus.we, bus.addr, bus.wdata} !== 35'd0) begin bad++; $display("FAIL rstbusy_bus got %h want 0", {stall, bus.req, bus.we, bus.addr, bus.wdata}); end
        total++; if ({wb_we, wb_waddr, wb_wdata, err} !== 22'd0) begin bad++; $display("FAIL rstbusy_wb got %h want 0", {wb_we, wb_waddr, wb_wdata, err}); end
        rst = 1'b0;
        ex_valid = 1'b1; ex_memop = 2'd0; ex_wreg = 1'b1; ex_waddr = 4'd2; ex_wdata = 16'hC0DE;
        @(negedge clk);
        ex_valid = 1'b0;
        total++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 4'd2, 16'hC0DE}) begin bad++; $display("FAIL rstbusy_alu got %h want %h", {wb_we, wb_waddr, wb_wdata}, {1'b1, 4'd2, 16'hC0DE}); end
        total++; if ({stall, bus.req} !== 2'b00) begin bad++; $display("FAIL rstbusy_idle got %b want 00", {stall, bus.req}); end
    endtask

    task automatic test_write_r0();
        @(negedge clk);
        ex_valid = 1'b1; ex_memop = 2'd0; ex_wreg = 1'b1; ex_waddr = 4'd0; ex_wdata = 16'hFFFF;
        @(negedge clk);
        ex_valid = 1'b0;
        total++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 4'd0, 16'hFFFF}) begin bad++; $display("FAIL r0_write got %h want %h", {wb_we, wb_waddr, wb_wdata}, {1'b1, 4'd0, 16'hFFFF}); end
        @(negedge clk);
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL r0_one_cycle got %b want 0", wb_we); end
    endtask

    initial begin
        bus.ack   = 1'b0;
        bus.rdata = '0;
        test_reset();
        test_alu_passthrough();
        test_mem_ops();
        test_reset_mid_busy();
        test_write_r0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
